// File: rtl/ahb_burst_sram_slave.sv
// AHB-Lite SRAM slave with programmable NSEQ/SEQ wait states and read-after-write forwarding.
// Define AHB_BURST_SRAM_RANGE_ERR_EN to return a two-cycle ERROR for out-of-range addresses.
module ahb_burst_sram_slave #(
  parameter int W_ADDR    = 32,
  parameter int W_DATA    = 32,
  parameter int DEPTH     = 1024,
  parameter int NSEQ_WAIT = 2,
  parameter int SEQ_WAIT  = 0,
  parameter     PRELOAD   = ""
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ahbls_hready_resp,
  input  logic              ahbls_hready,
  output logic              ahbls_hresp,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [2:0]        ahbls_hburst,
  input  logic [3:0]        ahbls_hprot,
  input  logic              ahbls_hmastlock,
  input  logic [W_DATA-1:0] ahbls_hwdata,
  output logic [W_DATA-1:0] ahbls_hrdata,
  output logic [2:0]        dbg_state
);

  localparam int NB   = W_DATA / 8;
  localparam int OFFW = $clog2(NB);
  localparam int IDXW = $clog2(DEPTH);
  localparam logic [3:0] NSEQ_W4 = 4'(NSEQ_WAIT);
  localparam logic [3:0] SEQ_W4  = 4'(SEQ_WAIT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR0 = 3'd3,
    S_ERR1 = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt, wait_cnt_nxt;
  logic [IDXW-1:0]   aph_idx, dp_idx, rd_idx;
  logic [NB-1:0]     aph_mask, dp_mask;
  logic [3:0]        aph_wait;
  logic              dp_write;
  logic              accept, aph_err, wr_commit;
  logic [W_DATA-1:0] mem [DEPTH];
  logic [W_DATA-1:0] rdata_q;
  logic              unused_ok;

  // Handshake: an address phase is taken when the bus HREADY and our HREADYOUT are both
  // high and HTRANS is NSEQ/SEQ; the data phase ends on the next cycle with HREADYOUT high.
  assign accept   = ahbls_hready && ahbls_hready_resp && ahbls_htrans[1];
  assign aph_idx  = ahbls_haddr[OFFW +: IDXW];
  assign aph_wait = ahbls_htrans[0] ? SEQ_W4 : NSEQ_W4;

`ifdef AHB_BURST_SRAM_RANGE_ERR_EN
  assign aph_err     = ((ahbls_haddr >> (OFFW + IDXW)) != '0) || (int'(aph_idx) >= DEPTH);
  assign ahbls_hresp = (state == S_ERR0) || (state == S_ERR1);
  assign unused_ok   = ^{ahbls_hburst, ahbls_hprot, ahbls_hmastlock};
`else
  assign aph_err     = 1'b0;
  assign ahbls_hresp = 1'b0;
  assign unused_ok   = ^{ahbls_haddr[W_ADDR-1:OFFW+IDXW], ahbls_hburst, ahbls_hprot,
                         ahbls_hmastlock};
`endif

  // Lanes belong to the transfer when they share the size-aligned group of the address.
  always_comb begin
    aph_mask = '0;
    if (int'(ahbls_hsize) >= OFFW) begin
      aph_mask = '1;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if ((b >> ahbls_hsize) == (int'(ahbls_haddr[OFFW-1:0]) >> ahbls_hsize))
          aph_mask[b] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt <= 4'd1) state_nxt = S_DATA;
      end
      S_ERR0: state_nxt = S_ERR1;
      default: begin
        if (!accept) begin
          state_nxt = S_IDLE;
        end else if (aph_err) begin
          state_nxt = S_ERR0;
        end else if (aph_wait != 4'd0) begin
          state_nxt    = S_WAIT;
          wait_cnt_nxt = aph_wait;
        end else begin
          state_nxt = S_DATA;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      dp_idx   <= '0;
      dp_mask  <= '0;
      dp_write <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        dp_idx   <= aph_idx;
        dp_mask  <= aph_mask;
        dp_write <= ahbls_hwrite && !aph_err;
      end
    end
  end

  assign ahbls_hready_resp = (state != S_WAIT) && (state != S_ERR0);
  assign dbg_state         = state;
  assign wr_commit         = (state == S_DATA) && dp_write;
  assign rd_idx            = ahbls_hready ? aph_idx : dp_idx;

  // A write finishing on the same edge as a reset still lands; memory itself never resets.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int b = 0; b < NB; b++) begin
        if (dp_mask[b]) mem[dp_idx][8*b +: 8] <= ahbls_hwdata[8*b +: 8];
      end
    end
  end

  // Written lanes bypass the array so a read taken in the write's final cycle sees new bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        rdata_q[8*b +: 8] <= (wr_commit && dp_mask[b] && (dp_idx == rd_idx))
                             ? ahbls_hwdata[8*b +: 8] : mem[rd_idx][8*b +: 8];
      end
    end
  end

  assign ahbls_hrdata = rdata_q;

endmodule

// File: tb/tb_ahb_burst_sram_slave.sv
// Directed bench for ahb_burst_sram_slave: u_dut uses NSEQ_WAIT=2/SEQ_WAIT=0, u_dut3 uses SEQ_WAIT=3.
module tb_ahb_burst_sram_slave;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata;

  logic        hready_resp1, hresp1, hready_resp2, hresp2;
  logic [31:0] hrdata1, hrdata2;
  logic [2:0]  dbg1, dbg2;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ahb_burst_sram_slave #(.NSEQ_WAIT(2), .SEQ_WAIT(0)) u_dut (
    .clk(clk), .rst(rst),
    .ahbls_hready_resp(hready_resp1), .ahbls_hready(hready_resp1), .ahbls_hresp(hresp1),
    .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(htrans), .ahbls_hsize(hsize),
    .ahbls_hburst(3'b001), .ahbls_hprot(4'b0011), .ahbls_hmastlock(1'b0),
    .ahbls_hwdata(hwdata), .ahbls_hrdata(hrdata1), .dbg_state(dbg1)
  );

  ahb_burst_sram_slave #(.NSEQ_WAIT(2), .SEQ_WAIT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .ahbls_hready_resp(hready_resp2), .ahbls_hready(hready_resp2), .ahbls_hresp(hresp2),
    .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(htrans), .ahbls_hsize(hsize),
    .ahbls_hburst(3'b001), .ahbls_hprot(4'b0011), .ahbls_hmastlock(1'b0),
    .ahbls_hwdata(hwdata), .ahbls_hrdata(hrdata2), .dbg_state(dbg2)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic rdy(input int sel);
    return (sel != 0) ? hready_resp2 : hready_resp1;
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Single non-pipelined transfer; starts and ends #1 after a clock edge with the slave idle.
  task automatic xfer(input int sel, input logic wr, input logic [1:0] trans,
                      input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata,
                      output logic [31:0] rdata, output int dlen, output logic resp);
    haddr = addr; hwrite = wr; hsize = size; htrans = trans;
    @(posedge clk); #1;
    htrans = T_IDLE;
    hwdata = wdata;
    dlen   = 1;
    while (!rdy(sel) && dlen < 64) begin
      @(posedge clk); #1;
      dlen++;
    end
    if (!rdy(sel)) begin
      n_total++;
      $display("FAIL xfer_timeout addr=%h got hready_resp=0 want 1", addr);
    end
    rdata = (sel != 0) ? hrdata2 : hrdata1;
    resp  = (sel != 0) ? hresp2 : hresp1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; haddr = '0; hwrite = 1'b0; htrans = T_IDLE; hsize = 3'd2; hwdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_total++; if (hready_resp1 !== 1'b1) $display("FAIL reset_hready got %b want 1", hready_resp1); else n_pass++;
    n_total++; if (hresp1 !== 1'b0) $display("FAIL reset_hresp got %b want 0", hresp1); else n_pass++;
    n_total++; if (hrdata1 !== 32'h0) $display("FAIL reset_hrdata got %h want 0", hrdata1); else n_pass++;
    n_total++; if (dbg1 !== 3'd0) $display("FAIL reset_state got %0d want 0", dbg1); else n_pass++;
  endtask

  task automatic test_nseq_read();
    logic [31:0] rd; int dl; logic rs;
    xfer(0, 1'b1, T_NSEQ, 32'h40, 3'd2, 32'hCAFEF00D, rd, dl, rs);
    n_total++; if (dl !== 3) $display("FAIL nseq_write_len got %0d want 3", dl); else n_pass++;
    xfer(0, 1'b0, T_NSEQ, 32'h40, 3'd2, 32'h0, rd, dl, rs);
    n_total++; if (dl !== 3) $display("FAIL nseq_read_len got %0d want 3", dl); else n_pass++;
    n_total++; if (rd !== 32'hCAFEF00D) $display("FAIL nseq_read_data got %h want cafef00d", rd); else n_pass++;
    n_total++; if (rs !== 1'b0) $display("FAIL nseq_read_resp got %b want 0", rs); else n_pass++;
  endtask

  task automatic test_incr4();
    logic [31:0] rd, exp_w; int dl, len, total; logic rs;
    xfer(0, 1'b1, T_NSEQ, 32'h44, 3'd2, 32'hA1A1_0011, rd, dl, rs);
    xfer(0, 1'b1, T_NSEQ, 32'h48, 3'd2, 32'hA2A2_0012, rd, dl, rs);
    xfer(0, 1'b1, T_NSEQ, 32'h4C, 3'd2, 32'hA3A3_0013, rd, dl, rs);
    exp_q = '{32'hCAFEF00D, 32'hA1A1_0011, 32'hA2A2_0012, 32'hA3A3_0013};
    haddr = 32'h40; hwrite = 1'b0; hsize = 3'd2; htrans = T_NSEQ; total = 0;
    for (int beat = 0; beat < 4; beat++) begin
      @(posedge clk); #1;
      if (beat < 3) begin
        haddr  = 32'h40 + 32'(4 * (beat + 1));
        htrans = T_SEQ;
      end else begin
        htrans = T_IDLE;
      end
      len = 1;
      while (!hready_resp1 && len < 64) begin
        @(posedge clk); #1;
        len++;
      end
      total += len;
      exp_w = exp_q.pop_front();
      n_total++; if (len !== ((beat == 0) ? 3 : 1)) $display("FAIL incr4_len beat=%0d got %0d want %0d", beat, len, (beat == 0) ? 3 : 1); else n_pass++;
      n_total++; if (hrdata1 !== exp_w) $display("FAIL incr4_data beat=%0d got %h want %h", beat, hrdata1, exp_w); else n_pass++;
    end
    @(posedge clk); #1;
    n_total++; if (total !== 6) $display("FAIL incr4_total got %0d want 6", total); else n_pass++;
  endtask

  task automatic test_forward();
    logic [31:0] rd; int dl, n; logic rs;
    xfer(0, 1'b1, T_NSEQ, 32'h100, 3'd2, 32'h1122_3344, rd, dl, rs);
    haddr = 32'h101; hwrite = 1'b1; hsize = 3'd0; htrans = T_NSEQ;
    @(posedge clk); #1;
    htrans = T_IDLE; hwdata = 32'hEEEE_ABEE; n = 0;
    while (!hready_resp1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    n_total++; if (n !== 2) $display("FAIL fwd_write_waits got %0d want 2", n); else n_pass++;
    // Zero-wait SEQ read issued in the write's completion cycle
    haddr = 32'h100; hwrite = 1'b0; hsize = 3'd2; htrans = T_SEQ;
    @(posedge clk); #1;
    htrans = T_IDLE; hwdata = 32'h0;
    n_total++; if (hrdata1 !== 32'h1122_AB44) $display("FAIL fwd_data got %h want 1122ab44", hrdata1); else n_pass++;
    @(posedge clk); #1;
    xfer(0, 1'b1, T_NSEQ, 32'h102, 3'd1, 32'hBEEF_7777, rd, dl, rs);
    xfer(0, 1'b0, T_NSEQ, 32'h100, 3'd2, 32'h0, rd, dl, rs);
    n_total++; if (rd !== 32'hBEEF_AB44) $display("FAIL half_write_data got %h want beefab44", rd); else n_pass++;
  endtask

  task automatic test_range();
    logic [31:0] rd; int dl; logic rs;
    xfer(0, 1'b1, T_NSEQ, 32'h0, 3'd2, 32'h5A5A_0001, rd, dl, rs);
`ifdef AHB_BURST_SRAM_RANGE_ERR_EN
    haddr = 32'h1000; hwrite = 1'b0; hsize = 3'd2; htrans = T_NSEQ;
    @(posedge clk); #1;
    htrans = T_IDLE;
    n_total++; if (hready_resp1 !== 1'b0) $display("FAIL err0_hready got %b want 0", hready_resp1); else n_pass++;
    n_total++; if (hresp1 !== 1'b1) $display("FAIL err0_hresp got %b want 1", hresp1); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (hready_resp1 !== 1'b1) $display("FAIL err1_hready got %b want 1", hready_resp1); else n_pass++;
    n_total++; if (hresp1 !== 1'b1) $display("FAIL err1_hresp got %b want 1", hresp1); else n_pass++;
    @(posedge clk); #1;
    xfer(0, 1'b1, T_NSEQ, 32'h1000, 3'd2, 32'hDEAD_BEEF, rd, dl, rs);
    n_total++; if (rs !== 1'b1) $display("FAIL err_write_resp got %b want 1", rs); else n_pass++;
    n_total++; if (dl !== 2) $display("FAIL err_write_len got %0d want 2", dl); else n_pass++;
    xfer(0, 1'b0, T_NSEQ, 32'h0, 3'd2, 32'h0, rd, dl, rs);
    n_total++; if (rd !== 32'h5A5A_0001) $display("FAIL err_no_write got %h want 5a5a0001", rd); else n_pass++;
`else
    xfer(0, 1'b0, T_NSEQ, 32'h1000, 3'd2, 32'h0, rd, dl, rs);
    n_total++; if (rd !== 32'h5A5A_0001) $display("FAIL alias_data got %h want 5a5a0001", rd); else n_pass++;
    n_total++; if (rs !== 1'b0) $display("FAIL alias_resp got %b want 0", rs); else n_pass++;
    n_total++; if (dl !== 3) $display("FAIL alias_len got %0d want 3", dl); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int dl; logic rs;
    xfer(0, 1'b1, T_NSEQ, 32'h20, 3'd2, 32'h0F0F_0F0F, rd, dl, rs);
    haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; htrans = T_NSEQ;
    @(posedge clk); #1;
    htrans = T_IDLE; hwdata = 32'h1234_5678;
    n_total++; if (hready_resp1 !== 1'b0) $display("FAIL midrst_wait1 got %b want 0", hready_resp1); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++; if (hready_resp1 !== 1'b1) $display("FAIL midrst_hready got %b want 1", hready_resp1); else n_pass++;
    n_total++; if (hresp1 !== 1'b0) $display("FAIL midrst_hresp got %b want 0", hresp1); else n_pass++;
    n_total++; if (hrdata1 !== 32'h0) $display("FAIL midrst_hrdata got %h want 0", hrdata1); else n_pass++;
    n_total++; if (dbg1 !== 3'd0) $display("FAIL midrst_state got %0d want 0", dbg1); else n_pass++;
    xfer(0, 1'b0, T_NSEQ, 32'h20, 3'd2, 32'h0, rd, dl, rs);
    n_total++; if (rd !== 32'h0F0F_0F0F) $display("FAIL midrst_mem got %h want 0f0f0f0f", rd); else n_pass++;
  endtask

  task automatic test_idle_busy_seq();
    logic [31:0] rd; int dl; logic rs;
    htrans = T_IDLE;
    idle_cycles(8);
    xfer(1, 1'b1, T_NSEQ, 32'hC0, 3'd2, 32'h600D_F00D, rd, dl, rs);
    haddr = 32'hC4; htrans = T_IDLE;
    @(posedge clk); #1;
    n_total++; if (hready_resp2 !== 1'b1) $display("FAIL idle_hready got %b want 1", hready_resp2); else n_pass++;
    n_total++; if (hresp2 !== 1'b0) $display("FAIL idle_hresp got %b want 0", hresp2); else n_pass++;
    htrans = T_BUSY;
    @(posedge clk); #1;
    n_total++; if (hready_resp2 !== 1'b1) $display("FAIL busy_hready got %b want 1", hready_resp2); else n_pass++;
    n_total++; if (dbg2 !== 3'd0) $display("FAIL busy_state got %0d want 0", dbg2); else n_pass++;
    xfer(1, 1'b0, T_SEQ, 32'hC0, 3'd2, 32'h0, rd, dl, rs);
    n_total++; if (dl !== 4) $display("FAIL seq3_len got %0d want 4", dl); else n_pass++;
    n_total++; if (rd !== 32'h600D_F00D) $display("FAIL seq3_data got %h want 600df00d", rd); else n_pass++;
    n_total++; if (rs !== 1'b0) $display("FAIL seq3_resp got %b want 0", rs); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nseq_read();
    test_incr4();
    test_forward();
    test_range();
    test_reset_mid();
    test_idle_busy_seq();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
